// File: rtl/timer_cap_filter_pkg.sv
// Shared defaults, polarity encodings and helpers for the capture-input filter.
package timer_cap_filter_pkg;

   localparam int unsigned TIM_FLT_SYNC_STAGE   = 2;
   localparam int unsigned TIM_FLT_PSC_WIDTH    = 8;
   localparam int unsigned TIM_FLT_LEN_WIDTH    = 4;
   localparam int unsigned TIM_FLT_GLITCH_WIDTH = 8;

   localparam logic TIM_FLT_POL_NORM = 1'b0;
   localparam logic TIM_FLT_POL_INV  = 1'b1;

   // Filtered level doubles as the filter FSM state.
   typedef enum logic [0:0] {
      LvlLow  = 1'b0,
      LvlHigh = 1'b1
   } lvl_e;

   function automatic logic [TIM_FLT_GLITCH_WIDTH-1:0] glitch_sat_inc(
      input logic [TIM_FLT_GLITCH_WIDTH-1:0] val
   );
      if (&val) begin
         return val;
      end
      return val + 1'b1;
   endfunction

endpackage

// File: rtl/timer_cap_filter_if.sv
// Configuration, raw pin and filtered outputs of the capture-input filter.
// TIMER_CAP_FILTER_GLITCH_CNT_EN adds the rejected-glitch counter signals.
interface timer_cap_filter_if
   import timer_cap_filter_pkg::*;
#(
   parameter int unsigned PSC_WIDTH = TIM_FLT_PSC_WIDTH,
   parameter int unsigned FLT_WIDTH = TIM_FLT_LEN_WIDTH
);

   logic                 en_i;
   logic                 pol_i;
   logic [PSC_WIDTH-1:0] psc_i;
   logic [FLT_WIDTH-1:0] flt_len_i;
   logic                 dat_i;
   logic                 dat_o;
   logic                 rise_o;
   logic                 fall_o;
`ifdef TIMER_CAP_FILTER_GLITCH_CNT_EN
   logic                            glitch_clr_i;
   logic [TIM_FLT_GLITCH_WIDTH-1:0] glitch_cnt_o;

   modport master (
      output en_i, pol_i, psc_i, flt_len_i, dat_i, glitch_clr_i,
      input  dat_o, rise_o, fall_o, glitch_cnt_o
   );

   modport slave (
      input  en_i, pol_i, psc_i, flt_len_i, dat_i, glitch_clr_i,
      output dat_o, rise_o, fall_o, glitch_cnt_o
   );
`else
   modport master (
      output en_i, pol_i, psc_i, flt_len_i, dat_i,
      input  dat_o, rise_o, fall_o
   );

   modport slave (
      input  en_i, pol_i, psc_i, flt_len_i, dat_i,
      output dat_o, rise_o, fall_o
   );
`endif

endinterface

// File: rtl/timer_cap_filter_tick.sv
// Sample prescaler: one tick every psc_i+1 enabled cycles, restarting from 0 on enable.
module timer_cap_filter_tick #(
   parameter int unsigned PSC_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [PSC_WIDTH-1:0] psc_i,
   output logic                 tick_o
);

   logic [PSC_WIDTH-1:0] psc_cnt_q;
   logic [PSC_WIDTH-1:0] psc_cnt_d;

   // ">=" lets a lowered psc_i fire on the next cycle instead of wrapping.
   always_comb begin
      tick_o    = en_i && (psc_cnt_q >= psc_i);
      psc_cnt_d = psc_cnt_q + 1'b1;
      if (!en_i || tick_o) begin
         psc_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         psc_cnt_q <= '0;
      end else begin
         psc_cnt_q <= psc_cnt_d;
      end
   end

endmodule

// File: rtl/timer_cap_filter.sv
// Capture-pin conditioner: synchronizer, sample prescaler and N-sample glitch filter.
// TIMER_CAP_FILTER_GLITCH_CNT_EN adds a saturating rejected-glitch counter.
module timer_cap_filter
   import timer_cap_filter_pkg::*;
#(
   parameter int unsigned SYNC_STAGE = TIM_FLT_SYNC_STAGE,
   parameter int unsigned PSC_WIDTH  = TIM_FLT_PSC_WIDTH,
   parameter int unsigned FLT_WIDTH  = TIM_FLT_LEN_WIDTH
) (
   input logic               clk_i,
   input logic               rst_i,
   timer_cap_filter_if.slave cap_io
);

   logic [SYNC_STAGE-1:0] sync_q;
   logic                  smp;
   lvl_e                  smp_lvl;
   logic                  tick;

   lvl_e                  lvl_q, lvl_d;
   logic [FLT_WIDTH-1:0]  flt_cnt_q, flt_cnt_d;
   logic [FLT_WIDTH:0]    flt_cnt_inc;
   logic                  rise_q, rise_d;
   logic                  fall_q, fall_d;
   logic                  bypass;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGE-2:0], cap_io.dat_i};
      end
   end

   assign smp     = sync_q[SYNC_STAGE-1] ^ cap_io.pol_i;
   assign smp_lvl = lvl_e'(smp);
   assign bypass  = (cap_io.flt_len_i == '0);

   timer_cap_filter_tick #(
      .PSC_WIDTH (PSC_WIDTH)
   ) u_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (cap_io.en_i),
      .psc_i  (cap_io.psc_i),
      .tick_o (tick)
   );

   // One extra bit so flt_cnt+1 cannot wrap before the length compare.
   assign flt_cnt_inc = {1'b0, flt_cnt_q} + 1'b1;

   always_comb begin
      lvl_d     = lvl_q;
      flt_cnt_d = flt_cnt_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      if (!cap_io.en_i) begin
         flt_cnt_d = '0;
      end else if (bypass) begin
         flt_cnt_d = '0;
         if (smp_lvl != lvl_q) begin
            lvl_d  = smp_lvl;
            rise_d = (smp_lvl == LvlHigh);
            fall_d = (smp_lvl == LvlLow);
         end
      end else if (tick) begin
         if (smp_lvl == lvl_q) begin
            flt_cnt_d = '0;
         end else if (flt_cnt_inc < {1'b0, cap_io.flt_len_i}) begin
            flt_cnt_d = flt_cnt_inc[FLT_WIDTH-1:0];
         end else begin
            lvl_d     = smp_lvl;
            flt_cnt_d = '0;
            rise_d    = (smp_lvl == LvlHigh);
            fall_d    = (smp_lvl == LvlLow);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lvl_q     <= LvlLow;
         flt_cnt_q <= '0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         lvl_q     <= lvl_d;
         flt_cnt_q <= flt_cnt_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign cap_io.dat_o  = (lvl_q == LvlHigh);
   assign cap_io.rise_o = rise_q;
   assign cap_io.fall_o = fall_q;

`ifdef TIMER_CAP_FILTER_GLITCH_CNT_EN
   logic [TIM_FLT_GLITCH_WIDTH-1:0] glitch_cnt_q, glitch_cnt_d;
   logic                            glitch_evt;

   // A partial run that ended with the sample agreeing again is a rejected glitch.
   assign glitch_evt = tick && !bypass && (flt_cnt_q != '0) && (smp_lvl == lvl_q);

   always_comb begin
      glitch_cnt_d = glitch_cnt_q;
      if (cap_io.glitch_clr_i) begin
         glitch_cnt_d = '0;
      end else if (glitch_evt) begin
         glitch_cnt_d = glitch_sat_inc(glitch_cnt_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         glitch_cnt_q <= '0;
      end else begin
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   assign cap_io.glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_timer_cap_filter.sv
// Directed bench for timer_cap_filter: expected pulses are queued with their cycle,
// a negedge monitor pops and compares them; level checks are done inline.
module tb_timer_cap_filter;
   import timer_cap_filter_pkg::*;

   typedef struct {
      logic is_rise;
      int   cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   int   c;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   timer_cap_filter_if #(
      .PSC_WIDTH (TIM_FLT_PSC_WIDTH),
      .FLT_WIDTH (TIM_FLT_LEN_WIDTH)
   ) cap_if ();

   timer_cap_filter #(
      .SYNC_STAGE (TIM_FLT_SYNC_STAGE),
      .PSC_WIDTH  (TIM_FLT_PSC_WIDTH),
      .FLT_WIDTH  (TIM_FLT_LEN_WIDTH)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .cap_io (cap_if)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_pulse(input logic is_rise, input int t);
      exp_t e;
      e.is_rise = is_rise;
      e.cyc     = t;
      exp_q.push_back(e);
   endtask

   // Monitor: every pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      if (cap_if.rise_o || cap_if.fall_o) begin
         check("pulse_exclusive", int'(cap_if.rise_o && cap_if.fall_o), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse_cycle", cyc, -1);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_kind_rise", int'(cap_if.rise_o), int'(mon_e.is_rise));
            check("pulse_cycle", cyc, mon_e.cyc);
            check("pulse_new_level", int'(cap_if.dat_o), int'(mon_e.is_rise));
         end
      end
   end

   initial begin
      rst              = 1'b1;
      cap_if.en_i      = 1'b0;
      cap_if.pol_i     = TIM_FLT_POL_NORM;
      cap_if.psc_i     = '0;
      cap_if.flt_len_i = '0;
      cap_if.dat_i     = 1'b1;
`ifdef TIMER_CAP_FILTER_GLITCH_CNT_EN
      cap_if.glitch_clr_i = 1'b0;
`endif

      // Reset and idle
      step(3);
      check("reset_dat", int'(cap_if.dat_o), 0);
      check("reset_rise", int'(cap_if.rise_o), 0);
      check("reset_fall", int'(cap_if.fall_o), 0);
`ifdef TIMER_CAP_FILTER_GLITCH_CNT_EN
      check("reset_glitch_cnt", int'(cap_if.glitch_cnt_o), 0);
`endif
      rst = 1'b0;
      step(5);
      check("idle_disabled_dat", int'(cap_if.dat_o), 0);

      // Clean rise and fall, psc=0, len=4
      cap_if.dat_i = 1'b0;
      step(4);
      c = cyc;
      cap_if.en_i      = 1'b1;
      cap_if.psc_i     = 8'd0;
      cap_if.flt_len_i = 4'd4;
      cap_if.dat_i     = 1'b1;
      expect_pulse(1'b1, c + 6);
      go(c + 5);
      check("clean_rise_not_early", int'(cap_if.dat_o), 0);
      go(c + 7);
      check("clean_rise_one_cycle", int'(cap_if.rise_o), 0);
      check("clean_rise_level", int'(cap_if.dat_o), 1);

      c = cyc;
      cap_if.dat_i = 1'b0;
      expect_pulse(1'b0, c + 6);
      go(c + 8);
      check("clean_fall_level", int'(cap_if.dat_o), 0);

      // Three-sample glitch is rejected
      c = cyc;
      cap_if.dat_i = 1'b1;
      go(c + 3);
      cap_if.dat_i = 1'b0;
      go(c + 10);
      check("glitch3_level", int'(cap_if.dat_o), 0);
`ifdef TIMER_CAP_FILTER_GLITCH_CNT_EN
      check("glitch3_cnt", int'(cap_if.glitch_cnt_o), 1);
      cap_if.glitch_clr_i = 1'b1;
      step(1);
      cap_if.glitch_clr_i = 1'b0;
      check("glitch_clr", int'(cap_if.glitch_cnt_o), 0);
`endif

      // Exactly four samples is accepted, then filtered back down
      c = cyc;
      cap_if.dat_i = 1'b1;
      go(c + 4);
      cap_if.dat_i = 1'b0;
      expect_pulse(1'b1, c + 6);
      expect_pulse(1'b0, c + 10);
      go(c + 12);
      check("len4_pulse_final_level", int'(cap_if.dat_o), 0);

      // Prescaled: psc=3, len=2, prescaler restarted from 0
      cap_if.en_i  = 1'b0;
      cap_if.dat_i = 1'b1;
      step(4);
      c = cyc;
      cap_if.en_i      = 1'b1;
      cap_if.psc_i     = 8'd3;
      cap_if.flt_len_i = 4'd2;
      expect_pulse(1'b1, c + 8);
      go(c + 10);
      check("psc_rise_level", int'(cap_if.dat_o), 1);

      cap_if.en_i  = 1'b0;
      cap_if.dat_i = 1'b0;
      step(4);
      c = cyc;
      cap_if.en_i = 1'b1;
      expect_pulse(1'b0, c + 8);
      go(c + 10);
      check("psc_fall_level", int'(cap_if.dat_o), 0);

      cap_if.en_i = 1'b0;
      step(2);
      c = cyc;
      cap_if.en_i  = 1'b1;
      cap_if.dat_i = 1'b1;
      go(c + 5);
      cap_if.dat_i = 1'b0;
      go(c + 14);
      check("psc_pulse5_rejected", int'(cap_if.dat_o), 0);
`ifdef TIMER_CAP_FILTER_GLITCH_CNT_EN
      check("psc_glitch_cnt", int'(cap_if.glitch_cnt_o), 1);
`endif

      // Bypass with inverted polarity, then polarity flip on a static pin
      cap_if.en_i      = 1'b0;
      cap_if.psc_i     = 8'd0;
      cap_if.flt_len_i = 4'd0;
      cap_if.pol_i     = TIM_FLT_POL_INV;
      cap_if.dat_i     = 1'b1;
      step(4);
      cap_if.en_i = 1'b1;
      step(3);
      check("bypass_static_level", int'(cap_if.dat_o), 0);
      c = cyc;
      cap_if.dat_i = 1'b0;
      expect_pulse(1'b1, c + 3);
      go(c + 5);
      check("bypass_inv_level", int'(cap_if.dat_o), 1);
      c = cyc;
      cap_if.pol_i = TIM_FLT_POL_NORM;
      expect_pulse(1'b0, c + 1);
      go(c + 3);
      check("pol_flip_level", int'(cap_if.dat_o), 0);

      // Lowering flt_len_i below the running count fires on the next tick
      cap_if.flt_len_i = 4'd4;
      step(2);
      c = cyc;
      cap_if.dat_i = 1'b1;
      go(c + 4);
      cap_if.flt_len_i = 4'd1;
      expect_pulse(1'b1, c + 5);
      go(c + 7);
      check("len_lowered_level", int'(cap_if.dat_o), 1);
      c = cyc;
      cap_if.dat_i = 1'b0;
      expect_pulse(1'b0, c + 3);
      go(c + 5);
      check("len1_fall_level", int'(cap_if.dat_o), 0);

      // Disable mid-count restarts the filter from zero
      cap_if.flt_len_i = 4'd4;
      step(2);
      c = cyc;
      cap_if.dat_i = 1'b1;
      go(c + 4);
      cap_if.en_i = 1'b0;
      step(1);
      cap_if.en_i = 1'b1;
      expect_pulse(1'b1, c + 9);
      go(c + 7);
      check("en_restart_not_early", int'(cap_if.dat_o), 0);
      go(c + 11);
      check("en_restart_level", int'(cap_if.dat_o), 1);

      // Reset mid-count: level drops without a fall pulse
      c = cyc;
      cap_if.dat_i = 1'b0;
      go(c + 4);
      rst = 1'b1;
      step(1);
      check("rst_mid_level", int'(cap_if.dat_o), 0);
      check("rst_mid_fall", int'(cap_if.fall_o), 0);
      rst = 1'b0;
      go(c + 12);
      check("rst_mid_final_level", int'(cap_if.dat_o), 0);

      step(2);
      check("pending_pulses", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/timer_cap_filter.md
Name: timer_cap_filter

Overview:
- Digital input conditioner placed directly upstream of the timer capture channel.
- Takes the raw asynchronous capture pin, synchronizes it, and rejects glitches by requiring N consecutive agreeing samples at a programmable sample rate.
- Delivers a clean level plus single-cycle rise/fall pulses; the capture logic consumes these instead of the raw pin.

Parameters:
- SYNC_STAGE, 2: number of synchronizer flops on dat_i (≥2).
- PSC_WIDTH, 8: width of the sample-prescaler value.
- FLT_WIDTH, 4: width of the filter-length value / consecutive-sample counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  filter enable
- pol_i  in  1  1 = invert input before filtering
- psc_i  in  PSC_WIDTH  sample tick every psc_i+1 cycles
- flt_len_i  in  FLT_WIDTH  consecutive differing samples needed to change level; 0 = bypass
- dat_i  in  1  raw asynchronous capture input
- dat_o  out  1  filtered level
- rise_o  out  1  one-cycle pulse on filtered 0→1
- fall_o  out  1  one-cycle pulse on filtered 1→0

Behaviour:
- One clock (clk_i); reset is synchronous and active-high (rst_i). All state changes on the rising edge of clk_i.
- Reset values:
  - sync chain = 0; psc_cnt = 0; flt_cnt = 0.
  - dat_o = 0; rise_o = 0; fall_o = 0.
- Synchronizer: SYNC_STAGE flops. smp = last stage XOR pol_i.
- Prescaler:
  - psc_cnt increments each cycle while en_i=1.
  - tick = (psc_cnt >= psc_i). On tick, psc_cnt ← 0.
  - psc_i=0 gives a tick every cycle. The ">=" comparison makes a lowered psc_i mid-count take effect on the next cycle.
- Filter, on each tick when en_i=1 and flt_len_i≠0:
  - smp == dat_o: flt_cnt ← 0.
  - smp ≠ dat_o and flt_cnt+1 < flt_len_i: flt_cnt ← flt_cnt+1.
  - smp ≠ dat_o and flt_cnt+1 ≥ flt_len_i: dat_o ← smp; flt_cnt ← 0; pulse rise_o or fall_o.
- Bypass (flt_len_i=0, en_i=1): dat_o ← smp every cycle, ignoring ticks; pulses on every change; flt_cnt held at 0.
- Pulse timing:
  - rise_o/fall_o are registered.
  - They are high for exactly the first cycle in which dat_o shows the new value; otherwise 0.
  - Never both high in the same cycle.
- Latency with pin stable from cycle 0 and ticks every cycle: dat_o changes SYNC_STAGE + flt_len_i cycles after the pin edge (bypass: SYNC_STAGE + 1).
- en_i=0:
  - psc_cnt and flt_cnt cleared; dat_o held; no pulses.
  - Sync chain keeps running.
  - Re-enable restarts counting from 0.
- Changing pol_i flips smp. Treated as a normal input change: filtered, and pulses reported.
- flt_len_i lowered below the current flt_cnt: the next differing tick updates the level (≥ comparison).
- rst_i asserted mid-filter: all state returns to reset values on that edge; no pulse is emitted.
- flt_cnt cannot overflow: it is bounded by flt_len_i ≤ 2^FLT_WIDTH−1.

Optional Feature:
- Macro: TIMER_CAP_FILTER_GLITCH_CNT_EN.
- Defined:
  - Adds ports glitch_clr_i (in 1) and glitch_cnt_o (out 8).
  - On a tick with flt_cnt≠0 and smp==dat_o (rejected glitch), glitch_cnt_o increments, saturating at 255.
  - glitch_clr_i=1 clears it to 0, with priority over increment.
  - Reset value 0.
- Undefined: those ports and the counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared define/package file holds the defaults: TIM_FLT_SYNC_STAGE=2, TIM_FLT_PSC_WIDTH=8, TIM_FLT_LEN_WIDTH=4, TIM_FLT_GLITCH_WIDTH=8. Also the polarity encodings TIM_FLT_POL_NORM=0 and TIM_FLT_POL_INV=1.
- One sub-module, timer_cap_filter_tick: the prescaler counter (clk_i, rst_i, en_i, psc_i → tick_o). The synchronizer and filter FSM stay in the top module.

Test Plan:
- Reset/idle: rst_i=1 for 3 cycles with dat_i=1 → dat_o, rise_o, fall_o = 0. After release with en_i=0 → dat_o stays 0 and no pulses.
- Clean rise: en_i=1, psc_i=0, flt_len_i=4; dat_i 0→1 at cycle 0 and held → dat_o=1 and rise_o=1 at cycle 6 only; rise_o=0 at cycle 7.
- Glitch reject: psc_i=0, flt_len_i=4; dat_i high for 3 cycles then low → dat_o stays 0 and no pulse. With the macro defined: glitch_cnt_o=1, then 0 after glitch_clr_i.
- Prescaled: psc_i=3, flt_len_i=2; dat_i held high → dat_o rises after 2 ticks (8 cycles ±3 depending on tick phase). A high pulse of 5 cycles is rejected.
- Bypass and polarity: flt_len_i=0, pol_i=1; dat_i 1→0 → dat_o 0→1 after SYNC_STAGE+1 cycles with rise_o. Toggling pol_i with the pin static → fall_o.
- Mid-operation: flt_cnt=2 of 4, then en_i=0 for 1 cycle → counter cleared; a full 4 fresh samples are needed. Same setup with rst_i=1 instead → dat_o=0 and no pulse.
